block_motion_ctrl: RTL

//  Motion controller for the bouncing picture block in the HDMI video path.

---
 rtl/block_motion_ctrl.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/block_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : block_motion_ctrl
// Description : Frame-synchronous motion controller for the bouncing picture
//               block. The block advances once every FRAME_DIV frames, and
//               only after the last active pixel of a frame, so block_x and
//               block_y never change while a frame is being drawn.
//
// Ports       : pixel_clk   - pixel clock, rising edge
//               sys_rst     - asynchronous active-high reset
//               pixel_xpos  - current X position from timing generator (11b)
//               pixel_ypos  - current Y position from timing generator (11b)
//               run         - 1 = keep moving, 0 = freeze after current update
//               step_x      - X pixels per step, 0 freezes the X axis (4b)
//               step_y      - Y pixels per step, 0 freezes the Y axis (4b)
//               block_x     - block origin X (11b)
//               block_y     - block origin Y (11b)
//               h_direct    - 1 = moving right, 0 = moving left
//               v_direct    - 1 = moving down, 0 = moving up
//               pos_valid   - one-cycle pulse when block_x/block_y update
//               bounce      - one-cycle pulse, [0] X edge hit, [1] Y edge hit
//
// Revision    : 1.0 - initial release
// ============================================================================
module block_motion_ctrl #(
    parameter int H_DISP    = 1280,
    parameter int V_DISP    = 720,
    parameter int SIDE_W    = 40,
    parameter int BLOCK_W   = 97,
    parameter int FRAME_DIV = 1
) (
    input  logic        pixel_clk,
    input  logic        sys_rst,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    input  logic        run,
    input  logic [3:0]  step_x,
    input  logic [3:0]  step_y,
    output logic [10:0] block_x,
    output logic [10:0] block_y,
    output logic        h_direct,
    output logic        v_direct,
    output logic        pos_valid,
    output logic [1:0]  bounce
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [10:0] c_XMIN     = 11'(SIDE_W);
    localparam logic [10:0] c_YMIN     = 11'(SIDE_W);
    localparam logic [10:0] c_XMAX     = 11'(H_DISP - SIDE_W - BLOCK_W);
    localparam logic [10:0] c_YMAX     = 11'(V_DISP - SIDE_W - BLOCK_W);
    localparam logic [10:0] c_EOF_X    = 11'(H_DISP - 1);
    localparam logic [10:0] c_EOF_Y    = 11'(V_DISP - 1);
    localparam logic [7:0]  c_DIV_LAST = 8'(FRAME_DIV - 1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_WAIT_EOF = 3'd1;
    localparam logic [2:0] c_ST_CALC_X   = 3'd2;
    localparam logic [2:0] c_ST_CALC_Y   = 3'd3;
    localparam logic [2:0] c_ST_PUBLISH  = 3'd4;

    // ------------------------------------------------------------------------
    // One-axis move with exact clamping. Returns {hit, new_pos, new_dir}.
    // A step that reaches or passes a limit lands exactly on it and reverses
    // direction; a zero step holds position and direction unchanged.
    // ------------------------------------------------------------------------
    function automatic logic [12:0] f_axis(
        input logic [10:0] pos,
        input logic [3:0]  step,
        input logic        dir,
        input logic [10:0] lo,
        input logic [10:0] hi
    );
        logic [11:0] sum;
        logic [11:0] lo_plus;
        logic [10:0] nxt;
        logic        hit;
        logic        ndir;
        sum     = {1'b0, pos} + {8'd0, step};
        lo_plus = {1'b0, lo} + {8'd0, step};
        nxt     = pos;
        hit     = 1'b0;
        ndir    = dir;
        if (step != 4'd0) begin
            if (dir) begin
                if (sum >= {1'b0, hi}) begin
                    nxt  = hi;
                    hit  = 1'b1;
                    ndir = 1'b0;
                end else begin
                    nxt = sum[10:0];
                end
            end else begin
                if ({1'b0, pos} <= lo_plus) begin
                    nxt  = lo;
                    hit  = 1'b1;
                    ndir = 1'b1;
                end else begin
                    nxt = pos - {7'd0, step};
                end
            end
        end
        return {hit, nxt, ndir};
    endfunction

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [7:0]  r_frame_cnt;
    logic [3:0]  r_step_x;
    logic [3:0]  r_step_y;
    logic [10:0] r_nx;
    logic [10:0] r_ny;
    logic        r_nh;
    logic        r_nv;
    logic        r_bx;
    logic        r_by;
    logic [10:0] r_block_x;
    logic [10:0] r_block_y;
    logic        r_h_direct;
    logic        r_v_direct;
    logic        r_pos_valid;
    logic [1:0]  r_bounce;

    logic        w_eof;
    logic        w_last_frame;
    logic        w_latch;
    logic        w_cnt_inc;
    logic        w_cnt_clr;
    logic        w_calc_x;
    logic        w_calc_y;
    logic        w_publish;
    logic [12:0] w_ax;
    logic [12:0] w_ay;

    assign w_eof        = (pixel_xpos == c_EOF_X) && (pixel_ypos == c_EOF_Y);
    assign w_last_frame = (r_frame_cnt == c_DIV_LAST);

    // Axis results come from the published position, which is stable
    // for the whole update sequence.
    assign w_ax = f_axis(r_block_x, r_step_x, r_h_direct, c_XMIN, c_XMAX);
    assign w_ay = f_axis(r_block_y, r_step_y, r_v_direct, c_YMIN, c_YMAX);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic. Stopping takes priority over a coincident eof in
    // WAIT_EOF; once an update starts it always runs to PUBLISH.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (run) w_state_nxt = c_ST_WAIT_EOF;
            end
            c_ST_WAIT_EOF: begin
                if (!run) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_eof && w_last_frame) begin
                    w_state_nxt = c_ST_CALC_X;
                end
            end
            c_ST_CALC_X:  w_state_nxt = c_ST_CALC_Y;
            c_ST_CALC_Y:  w_state_nxt = c_ST_PUBLISH;
            c_ST_PUBLISH: w_state_nxt = c_ST_WAIT_EOF;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_latch   = 1'b0;
        w_cnt_inc = 1'b0;
        w_cnt_clr = 1'b0;
        w_calc_x  = 1'b0;
        w_calc_y  = 1'b0;
        w_publish = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_cnt_clr = 1'b1;
            end
            c_ST_WAIT_EOF: begin
                if (!run) begin
                    w_cnt_clr = 1'b1;
                end else if (w_eof) begin
                    if (w_last_frame) begin
                        w_cnt_clr = 1'b1;
                        w_latch   = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            c_ST_CALC_X:  w_calc_x  = 1'b1;
            c_ST_CALC_Y:  w_calc_y  = 1'b1;
            c_ST_PUBLISH: w_publish = 1'b1;
            default:      w_cnt_clr = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // Frame divider and step latch
    // ------------------------------------------------------------------------
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_frame_cnt <= 8'd0;
            r_step_x    <= 4'd0;
            r_step_y    <= 4'd0;
        end else begin
            if (w_cnt_clr) begin
                r_frame_cnt <= 8'd0;
            end else if (w_cnt_inc) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (w_latch) begin
                r_step_x <= step_x;
                r_step_y <= step_y;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Staged results: computed in CALC_X / CALC_Y, held until PUBLISH
    // ------------------------------------------------------------------------
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_nx <= c_XMIN;
            r_ny <= c_YMIN;
            r_nh <= 1'b1;
            r_nv <= 1'b1;
            r_bx <= 1'b0;
            r_by <= 1'b0;
        end else begin
            if (w_calc_x) begin
                r_bx <= w_ax[12];
                r_nx <= w_ax[11:1];
                r_nh <= w_ax[0];
            end
            if (w_calc_y) begin
                r_by <= w_ay[12];
                r_ny <= w_ay[11:1];
                r_nv <= w_ay[0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Published outputs: all fields change together in the PUBLISH cycle
    // ------------------------------------------------------------------------
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_block_x   <= c_XMIN;
            r_block_y   <= c_YMIN;
            r_h_direct  <= 1'b1;
            r_v_direct  <= 1'b1;
            r_pos_valid <= 1'b0;
            r_bounce    <= 2'b00;
        end else begin
            r_pos_valid <= w_publish;
            r_bounce    <= w_publish ? {r_by, r_bx} : 2'b00;
            if (w_publish) begin
                r_block_x  <= r_nx;
                r_block_y  <= r_ny;
                r_h_direct <= r_nh;
                r_v_direct <= r_nv;
            end
        end
    end

    assign block_x   = r_block_x;
    assign block_y   = r_block_y;
    assign h_direct  = r_h_direct;
    assign v_direct  = r_v_direct;
    assign pos_valid = r_pos_valid;
    assign bounce    = r_bounce;

endmodule
`default_nettype wire
